// File: rtl/seg_scan_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_disp_pkg
// Purpose  : Shared constants and helpers for the seven-segment scanner.
//            Active-low segment patterns, blank pattern, hex decoder and
//            parameter legality helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seg_disp_pkg;

   typedef logic [7:0] seg_pat_t;

   // seg[7:1] = a..g, seg[0] = dp; all active-low
   localparam seg_pat_t SEG_OFF = 8'hFF;

   localparam seg_pat_t HEX_0 = 8'h03;
   localparam seg_pat_t HEX_1 = 8'h9F;
   localparam seg_pat_t HEX_2 = 8'h25;
   localparam seg_pat_t HEX_3 = 8'h0D;
   localparam seg_pat_t HEX_4 = 8'h99;
   localparam seg_pat_t HEX_5 = 8'h49;
   localparam seg_pat_t HEX_6 = 8'h41;
   localparam seg_pat_t HEX_7 = 8'h1F;
   localparam seg_pat_t HEX_8 = 8'h01;
   localparam seg_pat_t HEX_9 = 8'h09;
   localparam seg_pat_t HEX_A = 8'h11;
   localparam seg_pat_t HEX_B = 8'hC1;
   localparam seg_pat_t HEX_C = 8'h63;
   localparam seg_pat_t HEX_D = 8'h85;
   localparam seg_pat_t HEX_E = 8'h61;
   localparam seg_pat_t HEX_F = 8'h71;

   // Decode one nibble; dp=1 lights the decimal point (drives seg[0] low).
   function automatic seg_pat_t hex_to_seg(input logic [3:0] nibble, input logic dp);
      seg_pat_t pat;
      pat = SEG_OFF;
      case (nibble)
         4'h0: pat = HEX_0;
         4'h1: pat = HEX_1;
         4'h2: pat = HEX_2;
         4'h3: pat = HEX_3;
         4'h4: pat = HEX_4;
         4'h5: pat = HEX_5;
         4'h6: pat = HEX_6;
         4'h7: pat = HEX_7;
         4'h8: pat = HEX_8;
         4'h9: pat = HEX_9;
         4'hA: pat = HEX_A;
         4'hB: pat = HEX_B;
         4'hC: pat = HEX_C;
         4'hD: pat = HEX_D;
         4'hE: pat = HEX_E;
         4'hF: pat = HEX_F;
      endcase
      return {pat[7:1], ~dp};
   endfunction

   function automatic bit digits_ok(input int digits);
      return (digits >= 1) && (digits <= 16);
   endfunction

   function automatic bit prescale_ok(input int prescale);
      return prescale >= 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_display_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_display_if
// Purpose  : Data-in / pins-out bundle of the seven-segment scanner.
// Signals  : data  [4*DIGITS] hex nibbles, digit 0 rightmost
//            dp    [DIGITS]   decimal point per digit, 1 = lit
//            blank [DIGITS]   per-digit blank mask, 1 = dark
//            an    [DIGITS]   one-hot active-low anode select
//            seg   [8]        active-low segments, seg[0] = dp
//            frame [1]        pulse on the edge selecting digit 0
// Modports : master = data source, slave = scanner
// Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_display_if #(
   parameter int DIGITS = 8
);
   logic [4*DIGITS-1:0] data;
   logic [DIGITS-1:0]   dp;
   logic [DIGITS-1:0]   blank;
   logic [DIGITS-1:0]   an;
   logic [7:0]          seg;
   logic                frame;

   modport master (output data, dp, blank, input an, seg, frame);
   modport slave  (input data, dp, blank, output an, seg, frame);
endinterface
`default_nettype wire

// File: rtl/seg_scan_display_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : seg_tick_gen
// Purpose  : Clock-enable prescaler; one-cycle tick every PRESCALE clocks.
//            The first tick after reset comes PRESCALE cycles after release.
// Ports    : clk    in  system clock
//            clr    in  synchronous active-high reset
//            tick_o out tick, high while the counter holds PRESCALE-1
// Revision : 1.0 - initial release
// ============================================================================
module seg_tick_gen #(
   parameter int PRESCALE = 2000,
   parameter int CNT_W    = $clog2(PRESCALE + 1)
) (
   input  logic clk,
   input  logic clr,
   output logic tick_o
);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick_o = (cnt_q == C_LAST);
   assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_display
// Purpose  : Multiplexed seven-segment scanner for DIGITS hex digits. A frame
//            snapshot of {data, dp, blank} is taken on the tick selecting
//            digit 0, so one frame never mixes two data words.
// Ports    : clk  in  system clock
//            clr  in  synchronous active-high reset
//            bus  slave modport of seg_scan_display_if
// Macro    : SEG_LEADING_ZERO_BLANK_EN - blank digits above the highest
//            nonzero nibble (digit 0 always shown).
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_display
   import seg_disp_pkg::*;
#(
   parameter int DIGITS   = 8,
   parameter int PRESCALE = 2000,
   parameter int CNT_W    = $clog2(PRESCALE + 1)
) (
   input  logic               clk,
   input  logic               clr,
   seg_scan_display_if.slave  bus
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DIGITS - 1);

   if (!digits_ok(DIGITS)) begin : g_bad_digits
      $error("seg_scan_display: DIGITS must be 1..16");
   end
   if (!prescale_ok(PRESCALE)) begin : g_bad_prescale
      $error("seg_scan_display: PRESCALE must be >= 1");
   end

   logic tick;

   seg_tick_gen #(
      .PRESCALE (PRESCALE),
      .CNT_W    (CNT_W)
   ) u_tick_gen (
      .clk    (clk),
      .clr    (clr),
      .tick_o (tick)
   );

   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] sh_data_q;
   logic [DIGITS-1:0]   sh_dp_q, sh_blank_q;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [7:0]          seg_q, seg_d;
   logic                frame_q;
   logic                wrap;
   logic [DIGITS-1:0]   live_blank;

   // Effective blank mask of the live inputs, as it will be snapshotted.
`ifdef SEG_LEADING_ZERO_BLANK_EN
   always_comb begin
      logic seen;
      seen       = 1'b0;
      live_blank = bus.blank;
      // Walk down from the top digit; everything above the first nonzero
      // nibble goes dark. Digit 0 is excluded so zero still shows "0".
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (bus.data[4*i +: 4] != 4'h0) seen = 1'b1;
         if (!seen) live_blank[i] = 1'b1;
      end
   end
`else
   assign live_blank = bus.blank;
`endif

   // wrap: this tick selects digit 0 and captures the new frame
   assign wrap  = tick && (idx_q == C_LAST_IDX);
   assign idx_d = wrap ? '0 : idx_q + 1'b1;

   always_comb begin
      logic [4*DIGITS-1:0] src_data;
      logic [DIGITS-1:0]   src_dp, src_blank, sel;
      logic [3:0]          nib;
      // The digit-0 slot shows the word being captured on this same edge.
      src_data  = wrap ? bus.data : sh_data_q;
      src_dp    = wrap ? bus.dp   : sh_dp_q;
      src_blank = wrap ? live_blank : sh_blank_q;
      sel       = DIGITS'(1) << idx_d;
      nib       = 4'(src_data >> {idx_d, 2'b00});
      if (|(src_blank & sel)) begin
         an_d  = '1;
         seg_d = SEG_OFF;
      end else begin
         an_d  = ~sel;
         seg_d = hex_to_seg(nib, |(src_dp & sel));
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         idx_q      <= C_LAST_IDX;
         an_q       <= '1;
         seg_q      <= SEG_OFF;
         sh_data_q  <= '0;
         sh_dp_q    <= '0;
         sh_blank_q <= '0;
         frame_q    <= 1'b0;
      end else begin
         frame_q <= wrap;
         if (tick) begin
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
         end
         if (wrap) begin
            sh_data_q  <= bus.data;
            sh_dp_q    <= bus.dp;
            sh_blank_q <= live_blank;
         end
      end
   end

   assign bus.an    = an_q;
   assign bus.seg   = seg_q;
   assign bus.frame = frame_q;
endmodule
`default_nettype wire
